// File: rtl/panxi_if_fetch.sv
// Instruction-fetch stage: issues in-order ibus reads for the current PC, tracks
// outstanding requests and buffers returned instructions for decode under valid/ready.
module panxi_if_fetch #(
  parameter int unsigned                PANXI_DW   = 32,
  parameter int unsigned                DEPTH      = 2,
  parameter logic [PANXI_DW-1:0]        NOP_INST   = 32'h00000013,
  parameter int unsigned                HOLD_WIDTH = 3,
  parameter logic [HOLD_WIDTH-1:0]      HOLD_NONE  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PANXI_DW-1:0]   pc_xi,
  input  logic                  jmp_en_xi,
  input  logic [HOLD_WIDTH-1:0] hold_flag_xi,
  output logic                  ibus_req_xo,
  output logic [PANXI_DW-1:0]   ibus_addr_xo,
  input  logic                  ibus_gnt_xi,
  input  logic                  ibus_rvalid_xi,
  input  logic [PANXI_DW-1:0]   ibus_rdata_xi,
  output logic                  inst_valid_xo,
  output logic [PANXI_DW-1:0]   inst_xo,
  output logic [PANXI_DW-1:0]   inst_addr_xo,
  input  logic                  id_ready_xi,
  output logic                  fetch_stall_xo,
  output logic                  err_xo
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [PANXI_DW-1:0] addr_q   [DEPTH];
  logic [PANXI_DW-1:0] buf_inst [DEPTH];
  logic [PANXI_DW-1:0] buf_addr [DEPTH];

  ptr_t a_wr, a_rd, b_wr, b_rd;
  cnt_t outstanding, buffered, discard;
  logic err_q;

  logic hold_none, credit, grant, resp, spurious, drop, push, pop;
  cnt_t out_after_resp;

  assign ibus_addr_xo  = pc_xi;
  assign inst_valid_xo = (buffered != '0);
  assign inst_xo       = inst_valid_xo ? buf_inst[b_rd] : NOP_INST;
  assign inst_addr_xo  = inst_valid_xo ? buf_addr[b_rd] : '0;
  assign err_xo        = err_q;

  always_comb begin
    hold_none      = (hold_flag_xi == HOLD_NONE);
    credit         = (({1'b0, outstanding} + {1'b0, buffered}) < DEPTH_C);
    // rst_n gating keeps the request and stall low while reset is held
    ibus_req_xo    = rst_n & credit & ~jmp_en_xi & hold_none;
    grant          = ibus_req_xo & ibus_gnt_xi;
    fetch_stall_xo = rst_n & ~jmp_en_xi & hold_none & ~grant;
    resp           = ibus_rvalid_xi & (outstanding != '0);
    spurious       = ibus_rvalid_xi & (outstanding == '0);
    drop           = resp & (discard != '0);
    push           = resp & (discard == '0) & ~jmp_en_xi;
    pop            = inst_valid_xo & id_ready_xi & ~jmp_en_xi;
    out_after_resp = outstanding - cnt_t'(resp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_wr        <= '0;
      a_rd        <= '0;
      b_wr        <= '0;
      b_rd        <= '0;
      outstanding <= '0;
      buffered    <= '0;
      discard     <= '0;
      err_q       <= 1'b0;
    end else begin
      if (grant) a_wr <= a_wr + ptr_t'(1);
      if (resp)  a_rd <= a_rd + ptr_t'(1);
      outstanding <= out_after_resp + cnt_t'(grant);
      // A flush empties the buffer and marks every still-pending response stale
      if (jmp_en_xi) begin
        b_wr     <= '0;
        b_rd     <= '0;
        buffered <= '0;
        discard  <= out_after_resp;
      end else begin
        if (push) b_wr <= b_wr + ptr_t'(1);
        if (pop)  b_rd <= b_rd + ptr_t'(1);
        buffered <= buffered + cnt_t'(push) - cnt_t'(pop);
        if (drop) discard <= discard - cnt_t'(1);
      end
      if (spurious) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (grant) addr_q[a_wr] <= pc_xi;
    if (push) begin
      buf_inst[b_wr] <= ibus_rdata_xi;
      buf_addr[b_wr] <= addr_q[a_rd];
    end
  end

endmodule

// File: doc/panxi_if_fetch.md
Name: panxi_if_fetch

Overview:
- Instruction-fetch stage directly downstream of the PC register: takes the current PC and issues read requests on the instruction bus (req/gnt/rvalid, in-order responses).
- Tracks outstanding requests and buffers returned instructions with their addresses.
- Presents instructions to the IF/ID boundary under valid/ready.
- Drives a stall back to the hold controller so the PC advances only when a request is accepted; discards stale responses after a jump.

Parameters:
- PANXI_DW, 32, data and address width.
- DEPTH, 2, maximum outstanding requests plus buffered instructions; power of two, ≥2.
- NOP_INST, 32'h00000013, value driven on inst_xo when no valid instruction is held.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_xi  in  PANXI_DW  current fetch address from the PC stage.
- jmp_en_xi  in  1  jump/flush from execute.
- hold_flag_xi  in  HOLD_WIDTH  pipeline hold code; any value other than HOLD_NONE suppresses new requests.
- ibus_req_xo  out  1  fetch request.
- ibus_addr_xo  out  PANXI_DW  request address, equal to pc_xi.
- ibus_gnt_xi  in  1  request accepted this cycle.
- ibus_rvalid_xi  in  1  read data valid; in order, earliest one cycle after the grant.
- ibus_rdata_xi  in  PANXI_DW  read data.
- inst_valid_xo  out  1  instruction available to decode.
- inst_xo  out  PANXI_DW  instruction, or NOP_INST when invalid.
- inst_addr_xo  out  PANXI_DW  address of inst_xo; 0 when invalid.
- id_ready_xi  in  1  decode consumes the head instruction when inst_valid_xo is also high.
- fetch_stall_xo  out  1  the PC must hold this cycle.
- err_xo  out  1  sticky protocol error.

Behaviour:
- Reset, asynchronous: all counters, FIFOs and discard count go to 0. Outputs during reset:
  - ibus_req_xo=0, inst_valid_xo=0, inst_xo=NOP_INST, inst_addr_xo=0, err_xo=0.
  - fetch_stall_xo=0.
- Counters:
  - outstanding = granted requests not yet answered, 0..DEPTH.
  - buffered = output-buffer occupancy, 0..DEPTH.
  - credit = (outstanding + buffered) < DEPTH.
- ibus_req_xo = credit & ~jmp_en_xi & (hold_flag_xi==HOLD_NONE). This is combinational; it may not depend on ibus_gnt_xi.
- Grant (req & gnt): push pc_xi into the address FIFO (depth DEPTH); outstanding+1.
- fetch_stall_xo = ~jmp_en_xi & (hold_flag_xi==HOLD_NONE) & ~(ibus_req_xo & ibus_gnt_xi). The PC therefore advances by 4 only on an accepted fetch, and loads the jump target regardless of this signal.
- Response (rvalid with outstanding>0): pop the address FIFO; outstanding-1.
  - If discard>0: decrement discard and drop the data.
  - Otherwise: push {addr, rdata} into the output buffer.
  - Credit guarantees the output buffer never overflows.
- Output buffer: a DEPTH-entry FIFO.
  - inst_valid_xo = buffered>0; inst_xo and inst_addr_xo show the head entry.
  - Pop on inst_valid_xo & id_ready_xi.
  - Push and pop in the same cycle keep occupancy unchanged.
- Minimum latency: grant in cycle N, rvalid in N+1, inst_valid_xo in N+2 (registered; no bypass).
- Flush (jmp_en_xi=1):
  - No request is issued that cycle.
  - At the clock edge the output buffer is emptied, including any same-cycle response push and ignoring any pop.
  - discard <= outstanding after this cycle's response decrement, i.e. every still-pending response is dropped.
  - The next cycle fetches pc_xi = the jump target.
- Hold:
  - No new requests are issued.
  - In-flight responses are still accepted into the buffer.
  - Decode may still pop.
- Protocol error: rvalid with outstanding==0 is ignored (no FIFO change) and sets err_xo until reset.
- Pointers wrap modulo DEPTH. Counter widths are clog2(DEPTH)+1.

Test Plan:
- Reset, then sequential fetch with gnt=1 always, rvalid one cycle after each grant, id_ready=1: PC 0,4,8,… requested every cycle while credit allows (DEPTH=2 → one stall cycle per pair); inst_addr_xo 0,4,8 in order; first inst_valid_xo two cycles after the first grant.
- Decode backpressure: id_ready=0 for 5 cycles: buffer fills, ibus_req_xo=0 once outstanding+buffered=2, fetch_stall_xo=1, no instruction lost or duplicated when id_ready returns.
- Grant withheld for 3 cycles with pc_xi=0x100: ibus_req_xo=1, ibus_addr_xo=0x100 and fetch_stall_xo=1 for all 3 cycles; a single push when gnt=1.
- Jump with 2 outstanding (0x10, 0x14) to 0x200: both responses are dropped; inst_valid_xo=0 until the 0x200 instruction arrives; inst_addr_xo=0x200 is the next valid output.
- Jump in the same cycle as rvalid and an id_ready pop: buffer is empty the next cycle; discard equals the remaining outstanding count.
- Spurious rvalid with nothing outstanding: err_xo=1 from the next cycle, no valid output. rst_n asserted mid-operation: immediate return to the reset values of all outputs.
